pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, optional skid entry, synchronous flush, and a stall-cycle counter. It generalises the fixed IF/ID latch with write-enable and flush into a reusable block for every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Upstream stalls come from backpressure (`out_ready`) instead of a separate write-enable. The skid entry lets `in_ready` be a registered signal, so hazard logic does not form a combinational path through the pipeline.

## Interface
- `DATA_W`, default 96: payload width. For IF/ID this is {PC[63:0], instruction[31:0]}.
- `SKID_EN`, default 1: 1 adds a second (skid) entry and makes `in_ready` registered; 0 gives a single entry with combinational `in_ready`.
- `CNT_W`, default 16: width of the stall counter.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `flush` input, 1: synchronous; discards all held entries.
- `in_valid` input, 1: upstream offers `in_data`.
- `in_ready` output, 1: stage can accept; a transfer occurs when `in_valid && in_ready` (in_fire).
- `in_data` input, `DATA_W`: upstream payload.
- `out_valid` output, 1: `out_data` holds a valid entry.
- `out_ready` input, 1: downstream accepts; a transfer occurs when `out_valid && out_ready` (out_fire).
- `out_data` output, `DATA_W`: registered payload from the main entry.
- `stall_cycles` output, `CNT_W`: saturating count of backpressure cycles.

## Operation
- Storage:
  - Main entry: `main_valid`, `main_data`; drives `out_valid` and `out_data` directly.
  - Skid entry: `skid_valid`, `skid_data`; present only when `SKID_EN=1`.
- States with `SKID_EN=1`:
  - EMPTY: neither entry valid.
  - FULL: main valid, skid empty.
  - SKID: both entries valid.
- Transitions (`SKID_EN=1`):
  - EMPTY, in_fire -> FULL; `main_data <= in_data`.
  - FULL, in_fire and out_fire -> FULL; `main_data <= in_data`.
  - FULL, in_fire and no out_fire -> SKID; `skid_data <= in_data`.
  - FULL, out_fire and no in_fire -> EMPTY.
  - SKID, out_fire -> FULL; `main_data <= skid_data`. in_fire cannot occur in SKID.
  - No fire -> hold state and data.
- `in_ready` (`SKID_EN=1`) is registered and equals `!skid_valid`.
- `SKID_EN=0`:
  - Only EMPTY and FULL exist.
  - `in_ready = !main_valid || out_ready` (combinational).
  - Any in_fire loads `main_data` from `in_data`.
- Flush (`flush=1` in a cycle):
  - Next state is EMPTY.
  - `main_data` and `skid_data` are set to 0.
  - Any in_fire or out_fire in that same cycle is discarded.
  - `in_ready` is not gated by `flush`.
  - The downstream may still sample the pre-flush `out_data` in the flush cycle, but upstream data is dropped.
- Reset overrides flush and all traffic. After reset:
  - `out_valid=0`, `out_data=0`, `stall_cycles=0`.
  - `in_ready=1` in the first cycle after reset, for both modes.
- `stall_cycles`:
  - Increments by 1 on each cycle with `out_valid && !out_ready`.
  - Saturates at 2^`CNT_W`−1 and does not wrap.
  - Cleared by `reset` only; unaffected by `flush`.
- Ordering: entries leave in acceptance order. No duplication or loss occurs except on flush or reset.

## Timing
- Latency: `in_data` accepted at edge N appears on `out_data` with `out_valid=1` after edge N. It is visible in cycle N+1 if the stage was EMPTY, or at the edge where the preceding entry drains.
- Throughput: 1 transfer/cycle sustained while `out_ready=1` (FULL→FULL).
- `SKID_EN=1`:
  - Backpressure reaches `in_ready` one cycle late, and the skid entry absorbs that one in-flight transfer.
  - `in_ready` is a flop output.
  - `out_valid` and `out_data` never depend combinationally on inputs.
- `SKID_EN=0`: `in_ready` depends combinationally on `out_ready`.
- Simultaneous `reset` and `flush` behave as reset.
- `flush` together with a SKID→FULL drain yields EMPTY.

## Test plan
- Reset then stream: assert `reset` for 2 cycles, then present in_data = 0x…1000_00000013, 0x…1004_00100093 with `out_ready=1` continuously. Required:
  - `out_valid=0` and `out_data=0` while `reset` is asserted.
  - Each word appears on `out_data` one cycle after acceptance.
  - 1 word/cycle sustained; `stall_cycles=0`.
- Skid fill (`SKID_EN=1`): in FULL, drop `out_ready` while accepting word B. Required:
  - State becomes SKID, `in_ready=0`, `out_data` still shows word A.
  - After raising `out_ready`: A, then B, with no loss.
- Flush with both entries valid: assert `flush` for 1 cycle while `in_valid=1` with word C. Required:
  - Next cycle `out_valid=0` and `out_data=0`.
  - C is never output.
  - `in_ready=1`.
- Stall counter saturation with `CNT_W=4`: hold `out_valid=1` and `out_ready=0` for 20 cycles. Required:
  - `stall_cycles` counts 1..15 and stays at 15.
  - A flush does not clear it; only `reset` does.
- `SKID_EN=0`: with main valid, set `out_ready=1` and `in_valid=1` in the same cycle. Required:
  - `in_ready=1` in that cycle.
  - The new word replaces the main entry with no bubble.
  - With `out_ready=0`: `in_ready=0`.
- Reset mid-traffic: assert `reset` while in SKID state with `flush=1`. Required: EMPTY, all outputs at their reset values, and first post-reset in_fire behaves exactly like the first transfer of a fresh start.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating backpressure counter.
module pipe_stage_reg #(
  parameter int DATA_W  = 96,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic              in_fire, out_fire;

  // Outputs are pure decodes of flops, so nothing downstream sees an input path.
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] skid_data;

      // Ready drops one cycle after backpressure; the skid entry catches the in-flight word.
      assign in_ready = (state != SKID);

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          state     <= EMPTY;
          main_data <= '0;
          skid_data <= '0;
        end else begin
          case (state)
            EMPTY: if (in_fire) begin
              state     <= FULL;
              main_data <= in_data;
            end
            FULL: begin
              if (in_fire && out_fire) begin
                main_data <= in_data;
              end else if (in_fire) begin
                state     <= SKID;
                skid_data <= in_data;
              end else if (out_fire) begin
                state <= EMPTY;
              end
            end
            SKID: if (out_fire) begin
              state     <= FULL;
              main_data <= skid_data;
            end
            default: state <= EMPTY;
          endcase
        end
      end
    end else begin : g_noskid
      assign in_ready = (state == EMPTY) || out_ready;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          state     <= EMPTY;
          main_data <= '0;
        end else if (in_fire) begin
          state     <= FULL;
          main_data <= in_data;
        end else if (out_fire) begin
          state <= EMPTY;
        end
      end
    end
  endgenerate

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
